// File: rtl/pattern_driver_pkg.sv
// Shared types and LFSR helper for pattern_driver.
// Tap constant 16'hB400 serves both the stimulus LFSR and the MISR.
package pattern_driver_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } pd_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_step(
        input logic [15:0] s
    );
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pattern_driver_if.sv
// Response handshake bundle between pattern_driver and its consumer.
// The master side owns valid/data; the slave side owns ready.
interface pattern_driver_if #(
    parameter int OUT_W = 5
) ();

    logic             resp_valid;
    logic [OUT_W-1:0] resp_data;
    logic             resp_ready;

    modport master (
        output resp_valid,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        output resp_ready
    );

endinterface

// File: rtl/pd_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load of SEED and step enable.
// A nonzero SEED keeps the register out of the all-zero lockup state.
module pd_lfsr16
    import pattern_driver_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= lfsr16_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/pattern_driver.sv
// LFSR stimulus driver / response capture stage for a combinational netlist.
// Define PATTERN_DRIVER_MISR_EN to build the 16-bit response signature MISR.
module pattern_driver
    import pattern_driver_pkg::*;
#(
    parameter int          IN_W   = 13,
    parameter int          OUT_W  = 5,
    parameter int          SETTLE = 4,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_patterns,
    output logic [IN_W-1:0]  vec_out,
    input  logic [OUT_W-1:0] resp_in,
    pattern_driver_if.master rsp,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    pd_state_t        r_state;
    logic [15:0]      r_remaining;
    logic [CW-1:0]    r_cnt;
    logic [IN_W-1:0]  r_vec;
    logic             r_resp_valid;
    logic [OUT_W-1:0] r_resp_data;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_capture;
    logic             w_last;
    logic [15:0]      w_lfsr_state;
    logic [15:0]      w_lfsr_next;

    assign w_load    = (r_state == S_IDLE) && start;
    assign w_capture = (r_state == S_SETTLE) && (r_cnt == '0);
    assign w_last    = (r_remaining == 16'd1);
    assign w_step    = (r_state == S_CAPTURE) && rsp.resp_ready && !w_last;

    pd_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_state (w_lfsr_state)
    );

    assign w_lfsr_next = lfsr16_step(w_lfsr_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_cnt        <= '0;
            r_vec        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= num_patterns;
                        r_busy      <= 1'b1;
                        if (num_patterns == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_vec   <= IN_W'(SEED);
                            r_cnt   <= CNT_INIT;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_resp_data  <= resp_in;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // valid is always high here, so ready alone completes the handshake
                    if (rsp.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_remaining  <= r_remaining - 16'd1;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_vec   <= IN_W'(w_lfsr_next);
                            r_cnt   <= CNT_INIT;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PATTERN_DRIVER_MISR_EN
    logic [15:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else if (w_load && (num_patterns != 16'd0)) begin
            r_sig <= '0;
        end else if (w_capture) begin
            r_sig <= lfsr16_step(r_sig) ^ 16'(resp_in);
        end
    end

    assign signature = r_sig;
`else
    assign signature = '0;
`endif

    assign vec_out        = r_vec;
    assign rsp.resp_valid = r_resp_valid;
    assign rsp.resp_data  = r_resp_data;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
